// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the instruction-memory loader.
//   INSTR_W    : instruction word width (32).
//   DEFAULT_AW : default instruction-memory word-address width.
//   ST_*       : 3-bit loader state encodings, also exposed as the state_t enum.
// Optional feature macro used by the loader files: IMEM_LOADER_CHECKSUM_EN.
package cpu_pkg;

   localparam int unsigned INSTR_W    = 32;
   localparam int unsigned DEFAULT_AW = 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LEN   = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_WRITE = 3'd3;
   localparam logic [2:0] ST_CHK   = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;
   localparam logic [2:0] ST_ERR   = 3'd6;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      LEN   = ST_LEN,
      DATA  = ST_DATA,
      WRITE = ST_WRITE,
      CHK   = ST_CHK,
      DONE  = ST_DONE,
      ERR   = ST_ERR
   } state_t;

endpackage

// File: rtl/loader_word_pack.sv
// loader_word_pack: packs a byte stream, MSB first, into 32-bit words.
// Ports:
//   clk, rstd  : clock, asynchronous active-low reset
//   clr        : clear byte counter and checksum
//   push       : shift data into the word register
//   data       : incoming stream byte
//   word       : current shift-register contents
//   last_byte  : the next push completes a word (byte counter == 3)
//   csum       : running XOR of pushed bytes (0 unless IMEM_LOADER_CHECKSUM_EN)
// Macro: IMEM_LOADER_CHECKSUM_EN enables the checksum accumulator.
module loader_word_pack
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               rstd,
   input  logic               clr,
   input  logic               push,
   input  logic [7:0]         data,
   output logic [INSTR_W-1:0] word,
   output logic               last_byte,
   output logic [7:0]         csum
);

   logic [INSTR_W-1:0] shreg_q;
   logic [1:0]         byte_cnt_q;

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         shreg_q    <= '0;
         byte_cnt_q <= 2'd0;
      end else if (clr) begin
         byte_cnt_q <= 2'd0;
      end else if (push) begin
         shreg_q    <= {shreg_q[INSTR_W-9:0], data};
         byte_cnt_q <= byte_cnt_q + 2'd1;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] csum_q;

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         csum_q <= 8'd0;
      end else if (clr) begin
         csum_q <= 8'd0;
      end else if (push) begin
         csum_q <= csum_q ^ data;
      end
   end

   assign csum = csum_q;
`else
   assign csum = 8'd0;
`endif

   assign word      = shreg_q;
   assign last_byte = (byte_cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into instruction memory and
// holds the CPU in reset until the image is in place.
// Ports:
//   clk, rstd            : clock, asynchronous active-low reset
//   in_data/valid/ready  : byte stream handshake (transfer on valid && ready)
//   imem_we/addr/wdata   : instruction-memory write port, one strobe per word
//   cpu_rstd             : active-low CPU reset, released one cycle into DONE
//   done, err            : sticky status
// Macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and ERR path.
module imem_loader
   import cpu_pkg::*;
#(
   parameter int unsigned AW    = DEFAULT_AW,
   parameter int unsigned CNT_W = 8
) (
   input  logic               clk,
   input  logic               rstd,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               imem_we,
   output logic [AW-1:0]      imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               cpu_rstd,
   output logic               done,
   output logic               err
);

   localparam int unsigned CMP_W = (AW > CNT_W) ? AW : CNT_W;

   state_t             state_q;
   logic [AW-1:0]      word_idx_q;
   logic [CNT_W-1:0]   last_idx_q;
   logic [AW-1:0]      imem_addr_q;
   logic [INSTR_W-1:0] imem_wdata_q;
   logic               cpu_rstd_q;

   logic               xfer;
   logic               pack_clr;
   logic               pack_push;
   logic [INSTR_W-1:0] pack_word;
   logic               pack_last;
   logic [7:0]         pack_csum;
   logic               at_last_word;

   assign in_ready  = (state_q == LEN) || (state_q == DATA) || (state_q == CHK);
   assign xfer      = in_valid && in_ready;
   assign pack_clr  = (state_q == LEN) && xfer;
   assign pack_push = (state_q == DATA) && xfer;

   // Widen both sides so AW and CNT_W may differ.
   assign at_last_word = (CMP_W'(word_idx_q) == CMP_W'(last_idx_q));

   loader_word_pack u_pack (
      .clk       (clk),
      .rstd      (rstd),
      .clr       (pack_clr),
      .push      (pack_push),
      .data      (in_data),
      .word      (pack_word),
      .last_byte (pack_last),
      .csum      (pack_csum)
   );

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         state_q      <= IDLE;
         word_idx_q   <= '0;
         last_idx_q   <= '0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         cpu_rstd_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: state_q <= LEN;
            LEN: begin
               if (xfer) begin
                  // L=0 wraps to all-ones, i.e. the full 2^CNT_W words.
                  last_idx_q <= CNT_W'(in_data) - CNT_W'(1);
                  word_idx_q <= '0;
                  state_q    <= DATA;
               end
            end
            DATA: begin
               if (xfer && pack_last) begin
                  // Capture the completed word now so the write port is valid
                  // throughout WRITE and holds afterwards.
                  imem_addr_q  <= word_idx_q;
                  imem_wdata_q <= {pack_word[INSTR_W-9:0], in_data};
                  state_q      <= WRITE;
               end
            end
            WRITE: begin
               if (at_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_q <= CHK;
`else
                  state_q <= DONE;
`endif
               end else begin
                  word_idx_q <= word_idx_q + AW'(1);
                  state_q    <= DATA;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
               if (xfer) begin
                  state_q <= (in_data == pack_csum) ? DONE : ERR;
               end
            end
`endif
            DONE: cpu_rstd_q <= 1'b1;
            ERR:  cpu_rstd_q <= 1'b0;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign imem_we    = (state_q == WRITE);
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign cpu_rstd   = cpu_rstd_q;
   assign done       = (state_q == DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign err        = (state_q == ERR);
`else
   assign err        = 1'b0;
   logic unused_csum;
   assign unused_csum = ^pack_csum;
`endif

   logic unused_word_msb;
   assign unused_word_msb = ^pack_word[INSTR_W-1:INSTR_W-8];

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
// Adapts to IMEM_LOADER_CHECKSUM_EN (checksum bytes sent only when defined).
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rstd = 1'b1;
   logic [7:0]  in_data = 8'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_rstd;
   logic        done;
   logic        err;

   int checks = 0;
   int failures = 0;
   int unsigned cyc = 0;

   logic [7:0]  wr_addr[$];
   logic [31:0] wr_data[$];

   imem_loader #(.AW(8), .CNT_W(8)) dut (
      .clk        (clk),
      .rstd       (rstd),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rstd   (cpu_rstd),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_wdata);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the byte transfers.
   task automatic send(input logic [7:0] b);
      int n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("send_timeout", 32'(n), 32'd0);
      end else begin
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstd = 1'b0;
      idle(2);
      wr_addr.delete();
      wr_data.delete();
      rstd = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_end();
      int n = 0;
      while (!done && !err && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("end_reached", 32'(done | err), 32'd1);
   endtask

   initial begin
      int unsigned t0;
      int n;
      int bad;

      // Reset values.
      #2 rstd = 1'b0;
      idle(2);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_we", 32'(imem_we), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'd0);
      check("rst_wdata", imem_wdata, 32'd0);
      check("rst_cpu_rstd", 32'(cpu_rstd), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rstd = 1'b1;
      check("idle_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("ready_after_one_clk", 32'(in_ready), 32'd1);

      // Test 1: L=1, full rate.
      send(8'h01);
      t0 = cyc;
      send(8'h04); send(8'h20); send(8'h00); send(8'h05);
      check("t1_we", 32'(imem_we), 32'd1);
      check("t1_addr", 32'(imem_addr), 32'd0);
      check("t1_wdata", imem_wdata, 32'h0420_0005);
      check("t1_ready_in_write", 32'(in_ready), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h21);
      check("t1_done", 32'(done), 32'd1);
`else
      check("t1_not_done_in_write", 32'(done), 32'd0);
      @(negedge clk);
      check("t1_done_after_write", 32'(done), 32'd1);
`endif
      check("t1_cpu_rstd_lags", 32'(cpu_rstd), 32'd0);
      n = 0;
      while (!cpu_rstd && n < 20) begin
         @(negedge clk);
         n++;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      check("t1_cpu_rstd_delay", cyc - t0, 32'd7);
`else
      check("t1_cpu_rstd_delay", cyc - t0, 32'd6);
`endif
      idle(2);
      check("t1_wr_count", 32'(wr_addr.size()), 32'd1);
      check("t1_err", 32'(err), 32'd0);
      check("t1_ready_after", 32'(in_ready), 32'd0);
      check("t1_addr_hold", 32'(imem_addr), 32'd0);
      check("t1_wdata_hold", imem_wdata, 32'h0420_0005);

      // Test 2: L=2 with 1-cycle gaps.
      do_reset();
      send(8'h02); idle(1);
      send(8'h00); idle(1); send(8'h00); idle(1); send(8'h00); idle(1); send(8'h01); idle(1);
      send(8'hA0); idle(1); send(8'h00); idle(1); send(8'h00); idle(1); send(8'h00); idle(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'hA1);
`endif
      wait_end();
      idle(3);
      check("t2_done", 32'(done), 32'd1);
      check("t2_wr_count", 32'(wr_addr.size()), 32'd2);
      if (wr_addr.size() == 2) begin
         check("t2_addr0", 32'(wr_addr[0]), 32'd0);
         check("t2_data0", wr_data[0], 32'h0000_0001);
         check("t2_addr1", 32'(wr_addr[1]), 32'd1);
         check("t2_data1", wr_data[1], 32'hA000_0000);
      end
      check("t2_cpu_rstd", 32'(cpu_rstd), 32'd1);

      // Test 3: wrong checksum, or a stray byte after DONE without the checksum.
      do_reset();
      send(8'h01);
      send(8'h04); send(8'h20); send(8'h00); send(8'h05);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h22);
      check("t3_err", 32'(err), 32'd1);
      check("t3_done", 32'(done), 32'd0);
      idle(3);
      check("t3_cpu_rstd", 32'(cpu_rstd), 32'd0);
      check("t3_ready", 32'(in_ready), 32'd0);
      check("t3_err_sticky", 32'(err), 32'd1);
`else
      @(negedge clk);
      in_data  = 8'h22;
      in_valid = 1'b1;
      idle(3);
      check("t3_ready_done", 32'(in_ready), 32'd0);
      check("t3_err_tied", 32'(err), 32'd0);
      check("t3_done", 32'(done), 32'd1);
      in_valid = 1'b0;
`endif
      check("t3_wr_count", 32'(wr_addr.size()), 32'd1);

      // Test 4: L=0 -> 256 words, word i = i.
      do_reset();
      send(8'h00);
      for (int i = 0; i < 256; i++) begin
         send(8'h00); send(8'h00); send(8'h00); send(8'(i));
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h00);
`endif
      wait_end();
      idle(2);
      check("t4_done", 32'(done), 32'd1);
      check("t4_err", 32'(err), 32'd0);
      check("t4_wr_count", 32'(wr_addr.size()), 32'd256);
      if (wr_addr.size() == 256) begin
         bad = 0;
         for (int i = 0; i < 256; i++) begin
            if (wr_addr[i] !== 8'(i) || wr_data[i] !== 32'(i)) bad++;
         end
         check("t4_all_words", 32'(bad), 32'd0);
         check("t4_last_addr", 32'(wr_addr[255]), 32'hFF);
         check("t4_last_data", wr_data[255], 32'h0000_00FF);
      end

      // Test 5: reset mid-load, then a fresh load.
      do_reset();
      send(8'h02);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      send(8'h05); send(8'h06);
      check("t5_pre_wdata", imem_wdata, 32'h0102_0304);
      rstd = 1'b0;
      #1;
      check("t5_rst_ready", 32'(in_ready), 32'd0);
      check("t5_rst_we", 32'(imem_we), 32'd0);
      check("t5_rst_addr", 32'(imem_addr), 32'd0);
      check("t5_rst_wdata", imem_wdata, 32'd0);
      check("t5_rst_cpu", 32'(cpu_rstd), 32'd0);
      check("t5_rst_done", 32'(done), 32'd0);
      idle(2);
      wr_addr.delete();
      wr_data.delete();
      rstd = 1'b1;
      @(negedge clk);
      send(8'h01);
      send(8'h04); send(8'h20); send(8'h00); send(8'h05);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h21);
`endif
      wait_end();
      idle(2);
      check("t5_done", 32'(done), 32'd1);
      check("t5_wr_count", 32'(wr_addr.size()), 32'd1);
      if (wr_addr.size() == 1) begin
         check("t5_addr", 32'(wr_addr[0]), 32'd0);
         check("t5_data", wr_data[0], 32'h0420_0005);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
